// File: rtl/axi_ar_qos_allocator_if.sv
// AR channel bundle for axi_ar_qos_allocator: N per-port read-address requests in,
// one granted read-address beat out, plus per-port burst-completion pulses.
interface axi_ar_qos_allocator_if #(
    parameter int AXI_ADDRESS_W = 32,
    parameter int AXI_USER_W    = 6,
    parameter int N_TARG_PORT   = 7,
    parameter int LOG_N_TARG    = $clog2(N_TARG_PORT),
    parameter int AXI_ID_IN     = 16,
    parameter int AXI_ID_OUT    = AXI_ID_IN + LOG_N_TARG
);
    logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]     arid_i;
    logic [N_TARG_PORT-1:0][AXI_ADDRESS_W-1:0] araddr_i;
    logic [N_TARG_PORT-1:0][7:0]               arlen_i;
    logic [N_TARG_PORT-1:0][2:0]               arsize_i;
    logic [N_TARG_PORT-1:0][1:0]               arburst_i;
    logic [N_TARG_PORT-1:0]                    arlock_i;
    logic [N_TARG_PORT-1:0][3:0]               arcache_i;
    logic [N_TARG_PORT-1:0][2:0]               arprot_i;
    logic [N_TARG_PORT-1:0][3:0]               arregion_i;
    logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]    aruser_i;
    logic [N_TARG_PORT-1:0][3:0]               arqos_i;
    logic [N_TARG_PORT-1:0]                    arvalid_i;
    logic [N_TARG_PORT-1:0]                    arready_o;
    logic [N_TARG_PORT-1:0]                    rdone_i;

    logic [AXI_ID_OUT-1:0]    arid_o;
    logic [AXI_ADDRESS_W-1:0] araddr_o;
    logic [7:0]               arlen_o;
    logic [2:0]               arsize_o;
    logic [1:0]               arburst_o;
    logic                     arlock_o;
    logic [3:0]               arcache_o;
    logic [2:0]               arprot_o;
    logic [3:0]               arregion_o;
    logic [AXI_USER_W-1:0]    aruser_o;
    logic [3:0]               arqos_o;
    logic                     arvalid_o;
    logic                     arready_i;

    // Allocator view: takes requests, drives the granted beat.
    modport slave (
        input  arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arlock_i, arcache_i,
               arprot_i, arregion_i, aruser_i, arqos_i, arvalid_i, rdone_i, arready_i,
        output arready_o, arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arlock_o,
               arcache_o, arprot_o, arregion_o, aruser_o, arqos_o, arvalid_o
    );

    modport master (
        output arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arlock_i, arcache_i,
               arprot_i, arregion_i, aruser_i, arqos_i, arvalid_i, rdone_i, arready_i,
        input  arready_o, arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arlock_o,
               arcache_o, arprot_o, arregion_o, aruser_o, arqos_o, arvalid_o
    );
endinterface

// File: rtl/axi_ar_qos_allocator.sv
// AXI read-address allocator: QoS/round-robin arbitration with per-port outstanding limits.
// Define AXI_AR_ALLOC_QOS_EN to arbitrate by arqos first; otherwise pure round-robin.
module axi_ar_qos_allocator #(
    parameter int AXI_ADDRESS_W   = 32,
    parameter int AXI_USER_W      = 6,
    parameter int N_TARG_PORT     = 7,
    parameter int LOG_N_TARG      = $clog2(N_TARG_PORT),
    parameter int AXI_ID_IN       = 16,
    parameter int AXI_ID_OUT      = AXI_ID_IN + LOG_N_TARG,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic                  clk,
    input logic                  rst,
    axi_ar_qos_allocator_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [CNT_W-1:0]       cnt [N_TARG_PORT];
    logic [LOG_N_TARG-1:0]  rr;
    logic [LOG_N_TARG-1:0]  win;
    logic [N_TARG_PORT-1:0] eligible;
    logic [N_TARG_PORT-1:0] inc;
    logic [N_TARG_PORT-1:0] dec;
    logic                   found;
    logic                   free;
    logic                   grant;

    logic                     vld_p0;
    logic [AXI_ID_OUT-1:0]    id_p0;
    logic [AXI_ADDRESS_W-1:0] addr_p0;
    logic [7:0]               len_p0;
    logic [2:0]               size_p0;
    logic [1:0]               burst_p0;
    logic                     lock_p0;
    logic [3:0]               cache_p0;
    logic [2:0]               prot_p0;
    logic [3:0]               region_p0;
    logic [AXI_USER_W-1:0]    user_p0;
    logic [3:0]               qos_p0;

    function automatic logic [LOG_N_TARG-1:0] next_ptr(input logic [LOG_N_TARG-1:0] p);
        if (int'(p) == N_TARG_PORT - 1)
            return '0;
        return p + 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < N_TARG_PORT; i++)
            eligible[i] = bus.arvalid_i[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
    end

    // Scan in round-robin order from rr; the first port seen wins among equals.
    always_comb begin
        int                    s;
        logic [LOG_N_TARG-1:0] idx;
`ifdef AXI_AR_ALLOC_QOS_EN
        logic [3:0]            best_qos;
        best_qos = '0;
`endif
        found = 1'b0;
        win   = '0;
        s     = 0;
        idx   = '0;
        for (int k = 0; k < N_TARG_PORT; k++) begin
            s = int'(rr) + k;
            if (s >= N_TARG_PORT)
                s = s - N_TARG_PORT;
            idx = LOG_N_TARG'(s);
`ifdef AXI_AR_ALLOC_QOS_EN
            if (eligible[idx] && (!found || (bus.arqos_i[idx] > best_qos))) begin
                found    = 1'b1;
                win      = idx;
                best_qos = bus.arqos_i[idx];
            end
`else
            if (eligible[idx] && !found) begin
                found = 1'b1;
                win   = idx;
            end
`endif
        end
    end

    assign free  = !vld_p0 || bus.arready_i;
    assign grant = found && free && !rst;

    always_comb begin
        bus.arready_o = '0;
        if (grant)
            bus.arready_o[win] = 1'b1;
    end

    always_comb begin
        for (int i = 0; i < N_TARG_PORT; i++) begin
            inc[i] = grant && (int'(win) == i);
            dec[i] = bus.rdone_i[i] && (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= '0;
            for (int i = 0; i < N_TARG_PORT; i++)
                cnt[i] <= '0;
        end else begin
            if (grant)
                rr <= next_ptr(win);
            for (int i = 0; i < N_TARG_PORT; i++) begin
                if (inc[i] && !dec[i])
                    cnt[i] <= cnt[i] + CNT_W'(1);
                else if (dec[i] && !inc[i])
                    cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

    // ---- stage p0: single-entry output register, refilled only when free
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            id_p0     <= '0;
            addr_p0   <= '0;
            len_p0    <= '0;
            size_p0   <= '0;
            burst_p0  <= '0;
            lock_p0   <= 1'b0;
            cache_p0  <= '0;
            prot_p0   <= '0;
            region_p0 <= '0;
            user_p0   <= '0;
            qos_p0    <= '0;
        end else begin
            if (free)
                vld_p0 <= found;
            if (grant) begin
                id_p0     <= {win, bus.arid_i[win]};
                addr_p0   <= bus.araddr_i[win];
                len_p0    <= bus.arlen_i[win];
                size_p0   <= bus.arsize_i[win];
                burst_p0  <= bus.arburst_i[win];
                lock_p0   <= bus.arlock_i[win];
                cache_p0  <= bus.arcache_i[win];
                prot_p0   <= bus.arprot_i[win];
                region_p0 <= bus.arregion_i[win];
                user_p0   <= bus.aruser_i[win];
                qos_p0    <= bus.arqos_i[win];
            end
        end
    end

    assign bus.arvalid_o  = vld_p0;
    assign bus.arid_o     = id_p0;
    assign bus.araddr_o   = addr_p0;
    assign bus.arlen_o    = len_p0;
    assign bus.arsize_o   = size_p0;
    assign bus.arburst_o  = burst_p0;
    assign bus.arlock_o   = lock_p0;
    assign bus.arcache_o  = cache_p0;
    assign bus.arprot_o   = prot_p0;
    assign bus.arregion_o = region_p0;
    assign bus.aruser_o   = user_p0;
    assign bus.arqos_o    = qos_p0;
endmodule

// File: tb/tb_axi_ar_qos_allocator.sv
// Bench for axi_ar_qos_allocator (4 ports, 2 outstanding): per-cycle vector table plus
// hand-written stall/reset sequences; granted beats are tracked in a scoreboard queue.
module tb_axi_ar_qos_allocator;
    localparam int N    = 4;
    localparam int MAXO = 2;
    localparam int AW   = 32;
    localparam int UW   = 6;
    localparam int IDI  = 16;
    localparam int LOGN = 2;
    localparam int IDO  = IDI + LOGN;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] salt;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    axi_ar_qos_allocator_if #(
        .AXI_ADDRESS_W(AW), .AXI_USER_W(UW), .N_TARG_PORT(N),
        .LOG_N_TARG(LOGN), .AXI_ID_IN(IDI), .AXI_ID_OUT(IDO)
    ) bus ();

    axi_ar_qos_allocator #(
        .AXI_ADDRESS_W(AW), .AXI_USER_W(UW), .N_TARG_PORT(N), .LOG_N_TARG(LOGN),
        .AXI_ID_IN(IDI), .AXI_ID_OUT(IDO), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [IDO-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [3:0]     qos;
        logic [UW-1:0]  user;
    } beat_t;

    typedef struct {
        logic        r;
        logic [3:0]  valid;
        logic [15:0] qos;
        logic        rdy;
        logic [3:0]  rdone;
        logic [3:0]  exp_ardy;
        logic        exp_vld;
    } vec_t;

    beat_t sb[$];
    vec_t  tbl[25];

    function automatic logic [IDI-1:0] f_id(input int p, input logic [7:0] s);
        return {8'(8'hA0 + p), s};
    endfunction
    function automatic logic [AW-1:0] f_addr(input int p, input logic [7:0] s);
        return {8'(p + 1), 16'h0000, s};
    endfunction
    function automatic logic [7:0] f_len(input int p, input logic [7:0] s);
        return s ^ 8'(p * 17);
    endfunction
    function automatic logic [UW-1:0] f_user(input int p, input logic [7:0] s);
        return 6'(p * 5) ^ s[5:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1ns later, then scoreboard pop/push.
    task automatic cyc(input logic r, input logic [3:0] v, input logic [15:0] q,
                       input logic rdy, input logic [3:0] rd,
                       input logic [3:0] exp_ardy, input logic exp_vld, input string tag);
        beat_t e;
        @(negedge clk);
        rst  = r;
        salt = salt + 8'd1;
        for (int p = 0; p < N; p++) begin
            bus.arid_i[LOGN'(p)]   = f_id(p, salt);
            bus.araddr_i[LOGN'(p)] = f_addr(p, salt);
            bus.arlen_i[LOGN'(p)]  = f_len(p, salt);
            bus.aruser_i[LOGN'(p)] = f_user(p, salt);
            bus.arqos_i[LOGN'(p)]  = q[4*p +: 4];
        end
        bus.arvalid_i = v;
        bus.arready_i = rdy;
        bus.rdone_i   = rd;
        #1;
        chk({tag, "_ardy"}, 64'(bus.arready_o), 64'(exp_ardy));
        chk({tag, "_vld"}, 64'(bus.arvalid_o), 64'(exp_vld));
        if (bus.arvalid_o === 1'b1 && rdy) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s_sb actual=beat_out required=no_beat", tag);
            end else begin
                e = sb.pop_front();
                chk({tag, "_id"}, 64'(bus.arid_o), 64'(e.id));
                chk({tag, "_addr"}, 64'(bus.araddr_o), 64'(e.addr));
                chk({tag, "_len"}, 64'(bus.arlen_o), 64'(e.len));
                chk({tag, "_qos"}, 64'(bus.arqos_o), 64'(e.qos));
                chk({tag, "_user"}, 64'(bus.aruser_o), 64'(e.user));
            end
        end
        if (r) begin
            sb.delete();
        end else begin
            for (int p = 0; p < N; p++) begin
                if (bus.arready_o[LOGN'(p)] === 1'b1 && v[p]) begin
                    e.id   = {LOGN'(p), f_id(p, salt)};
                    e.addr = f_addr(p, salt);
                    e.len  = f_len(p, salt);
                    e.qos  = q[4*p +: 4];
                    e.user = f_user(p, salt);
                    sb.push_back(e);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IDO-1:0] held_id;
        logic [AW-1:0]  held_addr;
        logic [3:0]     held_qos;

        //            r     valid  qos       rdy   rdone  ardy   vld
        tbl[0]  = '{1'b1, 4'hF, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b0};
        tbl[1]  = '{1'b0, 4'hF, 16'h0000, 1'b1, 4'h0, 4'h1, 1'b0};
        tbl[2]  = '{1'b0, 4'hF, 16'h0000, 1'b1, 4'h0, 4'h2, 1'b1};
        tbl[3]  = '{1'b0, 4'hF, 16'h0000, 1'b1, 4'h0, 4'h4, 1'b1};
        tbl[4]  = '{1'b0, 4'hF, 16'h0000, 1'b1, 4'h0, 4'h8, 1'b1};
        tbl[5]  = '{1'b0, 4'hF, 16'h0000, 1'b1, 4'h0, 4'h1, 1'b1};
        tbl[6]  = '{1'b0, 4'h1, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b1};
        tbl[7]  = '{1'b0, 4'h1, 16'h0000, 1'b1, 4'h1, 4'h0, 1'b0};
        tbl[8]  = '{1'b0, 4'h1, 16'h0000, 1'b1, 4'h0, 4'h1, 1'b0};
        tbl[9]  = '{1'b0, 4'h1, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b1};
        tbl[10] = '{1'b0, 4'h1, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b0};
        tbl[11] = '{1'b0, 4'h2, 16'h0000, 1'b1, 4'h2, 4'h2, 1'b0};
        tbl[12] = '{1'b0, 4'h2, 16'h0000, 1'b1, 4'h0, 4'h2, 1'b1};
        tbl[13] = '{1'b0, 4'h2, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b1};
        tbl[14] = '{1'b1, 4'h0, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b0};
        tbl[15] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h4, 4'h0, 1'b0};
        tbl[16] = '{1'b0, 4'h4, 16'h0000, 1'b1, 4'h0, 4'h4, 1'b0};
        tbl[17] = '{1'b0, 4'h4, 16'h0000, 1'b1, 4'h0, 4'h4, 1'b1};
        tbl[18] = '{1'b0, 4'h4, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b1};
        tbl[19] = '{1'b0, 4'h6, 16'h0000, 1'b1, 4'h0, 4'h2, 1'b0};
        tbl[20] = '{1'b1, 4'h0, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b1};
`ifdef AXI_AR_ALLOC_QOS_EN
        tbl[21] = '{1'b0, 4'hA, 16'h9020, 1'b1, 4'h0, 4'h8, 1'b0};
`else
        tbl[21] = '{1'b0, 4'hA, 16'h9020, 1'b1, 4'h0, 4'h2, 1'b0};
`endif
        tbl[22] = '{1'b0, 4'hA, 16'h9020, 1'b1, 4'h0, 4'h8, 1'b1};
        tbl[23] = '{1'b0, 4'hA, 16'h9020, 1'b1, 4'h0, 4'h2, 1'b1};
        tbl[24] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h0, 4'h0, 1'b1};

        rst  = 1'b1;
        salt = 8'd0;
        bus.arid_i     = '0;
        bus.araddr_i   = '0;
        bus.arlen_i    = '0;
        bus.arsize_i   = {N{3'd2}};
        bus.arburst_i  = {N{2'b01}};
        bus.arlock_i   = '0;
        bus.arcache_i  = {N{4'h3}};
        bus.arprot_i   = '0;
        bus.arregion_i = '0;
        bus.aruser_i   = '0;
        bus.arqos_i    = '0;
        bus.arvalid_i  = '0;
        bus.arready_i  = 1'b1;
        bus.rdone_i    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 64'(bus.arvalid_o), 64'd0);
        chk("rst_id", 64'(bus.arid_o), 64'd0);
        chk("rst_addr", 64'(bus.araddr_o), 64'd0);
        chk("rst_qos", 64'(bus.arqos_o), 64'd0);
        chk("rst_ardy", 64'(bus.arready_o), 64'd0);

        for (int i = 0; i < 25; i++)
            cyc(tbl[i].r, tbl[i].valid, tbl[i].qos, tbl[i].rdy, tbl[i].rdone,
                tbl[i].exp_ardy, tbl[i].exp_vld, $sformatf("v%0d", i));

        // Downstream stall: held beat must not move, no port may be granted.
        cyc(1'b1, 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 1'b0, "s_rst");
        cyc(1'b0, 4'h3, 16'h0, 1'b0, 4'h0, 4'h1, 1'b0, "s_g0");
        held_id   = '0;
        held_addr = '0;
        held_qos  = '0;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 4'h3, 16'h5555 ^ 16'(k), 1'b0, 4'h0, 4'h0, 1'b1, $sformatf("s_stall%0d", k));
            if (k == 0) begin
                held_id   = bus.arid_o;
                held_addr = bus.araddr_o;
                held_qos  = bus.arqos_o;
                chk("s_id_port", 64'(bus.arid_o[IDO-1:IDI]), 64'd0);
            end else begin
                chk($sformatf("s_hold_id%0d", k), 64'(bus.arid_o), 64'(held_id));
                chk($sformatf("s_hold_addr%0d", k), 64'(bus.araddr_o), 64'(held_addr));
                chk($sformatf("s_hold_qos%0d", k), 64'(bus.arqos_o), 64'(held_qos));
            end
        end
        cyc(1'b0, 4'h3, 16'h0, 1'b1, 4'h0, 4'h2, 1'b1, "s_rel");
        cyc(1'b0, 4'h3, 16'h0, 1'b1, 4'h0, 4'h1, 1'b1, "s_next");
        cyc(1'b0, 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 1'b1, "s_drain");
        cyc(1'b0, 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 1'b0, "s_idle");

        // Reset while a beat is stalled: beat dropped, counters and pointer cleared.
        cyc(1'b1, 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 1'b0, "h_rst0");
        cyc(1'b0, 4'h4, 16'h0, 1'b1, 4'h0, 4'h4, 1'b0, "h_g1");
        cyc(1'b0, 4'h4, 16'h0, 1'b1, 4'h0, 4'h4, 1'b1, "h_g2");
        cyc(1'b0, 4'h4, 16'h0, 1'b0, 4'h0, 4'h0, 1'b1, "h_stall");
        cyc(1'b1, 4'h4, 16'h0, 1'b0, 4'h0, 4'h0, 1'b1, "h_rst1");
        cyc(1'b0, 4'hA, 16'h0, 1'b0, 4'h0, 4'h2, 1'b0, "h_post");
        chk("h_post_id", 64'(bus.arid_o), 64'd0);
        cyc(1'b0, 4'h4, 16'h0, 1'b1, 4'h0, 4'h4, 1'b1, "h_cnt");
        cyc(1'b0, 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 1'b1, "h_drain");
        cyc(1'b0, 4'h0, 16'h0, 1'b1, 4'h0, 4'h0, 1'b0, "h_idle");
        chk("sb_left", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_ar_qos_allocator.md
AXI_AR_QOS_ALLOCATOR -- requirements
Module: axi_ar_qos_allocator

Interface
REQ-001 SHALL have parameter AXI_ADDRESS_W, default 32: address width.
REQ-002 SHALL have parameter AXI_USER_W, default 6: user field width.
REQ-003 SHALL have parameter N_TARG_PORT, default 7: number of requesting slave ports, at least 2.
REQ-004 SHALL have parameter LOG_N_TARG, default $clog2(N_TARG_PORT): port index width.
REQ-005 SHALL have parameter AXI_ID_IN, default 16: input ID width.
REQ-006 SHALL have parameter AXI_ID_OUT, default AXI_ID_IN+LOG_N_TARG: output ID width.
REQ-007 SHALL have parameter MAX_OUTSTANDING, default 4: per-port read bursts in flight, at least 1.
REQ-008 SHALL have clk, input, 1: single clock; all logic samples on its rising edge.
REQ-009 SHALL have rst, input, 1: reset, synchronous and active-high.
REQ-010 SHALL have arid_i/araddr_i/arlen_i(8)/arsize_i(3)/arburst_i(2)/arlock_i(1)/arcache_i(4)/arprot_i(3)/arregion_i(4)/aruser_i/arqos_i(4), input, N_TARG_PORT x field: per-port AR payload.
REQ-011 SHALL have arvalid_i, input, N_TARG_PORT: per-port AR valid.
REQ-012 SHALL have arready_o, output, N_TARG_PORT: per-port AR ready.
REQ-013 SHALL have araddr_o...arqos_o, output, same field widths: granted AR payload.
REQ-014 SHALL have arid_o, output, AXI_ID_OUT: {winner port index, arid}.
REQ-015 SHALL have arvalid_o (output, 1) and arready_i (input, 1): downstream AR handshake.
REQ-016 SHALL have rdone_i, input, N_TARG_PORT: one-cycle pulse per port on R handshake with rlast.

Function
REQ-017 SHALL present all ar*_o from a single-entry output register; grant-to-arvalid_o latency is 1 cycle.
REQ-018 SHALL hold ar*_o and arvalid_o stable while arvalid_o=1 and arready_i=0.
REQ-019 Output register free = !arvalid_o | arready_i; only then SHALL a grant occur, back-to-back bursts at 1 per cycle.
REQ-020 Port i eligible = arvalid_i[i] & (cnt[i] < MAX_OUTSTANDING).
REQ-021 SHALL assert arready_o only for the single winner, only when free; at most one bit set; arready_o is combinational from arvalid_i.
REQ-022 Winner: highest arqos among eligible ports; ties by round-robin starting at pointer rr.
REQ-023 On grant to port w, rr SHALL become (w+1) mod N_TARG_PORT; no grant, rr unchanged.
REQ-024 cnt[i] (width $clog2(MAX_OUTSTANDING+1)) SHALL +1 on grant to i, -1 on rdone_i[i], unchanged if both same cycle.
REQ-025 rdone_i[i] with cnt[i]=0 SHALL be ignored (no wrap).
REQ-026 A port at MAX_OUTSTANDING SHALL be skipped without stalling other ports.
REQ-027 arid_o[AXI_ID_OUT-1:AXI_ID_IN] SHALL equal the winner's binary index.

Reset
REQ-028 On rst=1 at a clock edge: arvalid_o=0, all ar*_o=0, all cnt=0, rr=0; arready_o=0 while rst=1.
REQ-029 rst mid-transfer SHALL drop any held output beat and clear counters; no recovery of in-flight bursts.

Configuration
REQ-030 With AXI_AR_ALLOC_QOS_EN defined: arbitration per REQ-022.
REQ-031 Without AXI_AR_ALLOC_QOS_EN: arqos ignored for arbitration, pure round-robin from rr; arqos_o still passed through.

Verification
REQ-032 N=4, ports 0..3 valid, equal qos, arready_i=1 -> grants 0,1,2,3,0 on consecutive cycles, arid_o MSBs = index.
REQ-033 QOS_EN: port1 qos=2, port3 qos=9, both valid -> port3 granted first; without macro -> port1 first (rr=0).
REQ-034 MAX_OUTSTANDING=2, port0 always valid, no rdone -> 2 grants then arready_o[0]=0; one rdone_i[0] pulse -> exactly 1 more grant.
REQ-035 arready_i=0 for 5 cycles after arvalid_o=1 -> ar*_o constant, arready_o=0 all ports; arready_i=1 -> next grant same cycle.
REQ-036 Grant and rdone_i same port same cycle with cnt=1 -> cnt stays 1; rdone_i with cnt=0 -> cnt stays 0.
REQ-037 rst=1 while arvalid_o=1 stalled -> next cycle arvalid_o=0, counters 0, first post-reset grant to lowest valid port.
